regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of reg_file between NUM_REQ writeback requesters: vector ALU, scalar ALU and load unit.
- Round-robin arbitration with a valid/ready handshake; the granted write is registered and drives regWrEnSc/regWrEnVec, regToWrite and dataIn one cycle later.
- Holds a per-register pending-write scoreboard so decode can stall reads of registers with writes still in flight.

Parameters:
- registerSize, 16, bits per lane
- registerQuantity, 4, registers per bank (vector bank = addresses 0..registerQuantity-1)
- selectionBits, 4, register address width (2**selectionBits architectural registers)
- vectorSize, 4, lanes per vector
- NUM_REQ, 3, number of writeback requesters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i holds a write
- req_ready  out  NUM_REQ  grant; write accepted when valid&ready
- req_reg  in  NUM_REQ x selectionBits  destination register per requester
- req_data  in  NUM_REQ x vectorSize x registerSize  write data per requester
- claim_valid  in  1  decode issued an instruction that will write claim_reg
- claim_reg  in  selectionBits  register being claimed
- claim_conflict  out  1  one-cycle pulse: claim hit an already-pending register
- rd_sel1, rd_sel2  in  selectionBits  operand selects, mirrored from reg_file rSel1/rSel2
- rd_busy1, rd_busy2  out  1  selected register has a pending write
- regWrEnSc  out  1  scalar bank write strobe to reg_file
- regWrEnVec  out  1  vector bank write strobe to reg_file
- regToWrite  out  selectionBits  write address to reg_file
- dataIn  out  vectorSize x registerSize  write data to reg_file

Behaviour:
- Reset (synchronous, active-high): regWrEnSc=0, regWrEnVec=0, regToWrite=0, dataIn=0, rr_ptr=0, pending all 0, claim_conflict=0. req_ready=0 while reset=1.
- Arbitration (combinational): scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ; the first index with req_valid set gets req_ready set. At most one ready bit per cycle; ready never asserts without valid.
- No back-pressure from reg_file, so a grant is available every cycle. Sustained throughput: 1 write/cycle.
- On accept of index g: rr_ptr <= (g+1) mod NUM_REQ. With no accept, rr_ptr holds.
- Output stage (registered, latency 1): the cycle after an accept, regToWrite=req_reg[g] and dataIn=req_data[g].
  - regWrEnVec=1 if req_reg < registerQuantity; otherwise regWrEnSc=1. Never both.
  - reg_file commits on the following edge. Strobes are single-cycle pulses.
  - With no accept, both strobes are 0; regToWrite and dataIn hold their last values.
- Scoreboard, per register: pending[r] <= (pending[r] & ~clear_r) | set_r.
  - set_r = claim_valid & claim_reg==r.
  - clear_r = write strobe active with regToWrite==r.
  - Set and clear on the same register in the same cycle: set wins (a newer producer is outstanding).
- claim_conflict pulses one cycle, registered, when claim_valid targets a register already pending and not being cleared that cycle. The pending bit stays 1.
- rd_busy1/rd_busy2 = pending[rd_sel*], combinational from registered state. Busy drops the cycle after the write strobe.
- Writes without a prior claim are legal; the clear is a no-op.
- Reset mid-operation: accepted-but-unwritten data is dropped and the strobe is suppressed on the next cycle.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed.
- Undefined: round-robin as above.

Decomposition:
- Package regfile_pkg holds:
  - constants REG_SIZE, VEC_SIZE, SEL_BITS, VEC_REGS
  - typedefs reg_addr_t and vec_data_t (vectorSize x registerSize)
  - function is_vector_reg(reg_addr_t)
- Sub-module rr_arbiter (NUM_REQ-wide request in, one-hot grant out, internal pointer update on accept), reusable for other shared resources.

Test Plan:
- Single write: reset, then req_valid[1]=1, req_reg=4, req_data=64'h0004000400040004 -> req_ready[1] the same cycle; next cycle regWrEnSc=1, regWrEnVec=0, regToWrite=4; reading rSel1=4 afterwards gives 64'h0004000400040004.
- Vector routing: req_reg=3, data=32'hDEADBEEF -> regWrEnVec=1 and regWrEnSc=0 one cycle later.
- Fairness: all three req_valid held 6 cycles -> grant order 0,1,2,0,1,2. With WB_FIXED_PRIO_EN defined -> 0 every cycle.
- Scoreboard: claim reg 13 -> rd_busy1=1 (rd_sel1=13) from the next cycle; write to 13 -> busy clears the cycle after the strobe. Claim 13 and write 13 in the same cycle -> busy stays 1.
- Conflict: claim 14 twice without an intervening write -> claim_conflict=1 for exactly one cycle.
- Reset mid-flight: accept a write to reg 7, assert reset the next cycle -> no strobe, pending=0, rr_ptr=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants, types and helpers for the reg_file writeback path.
package regfile_pkg;

   localparam int unsigned REG_SIZE = 16;
   localparam int unsigned VEC_SIZE = 4;
   localparam int unsigned SEL_BITS = 4;
   localparam int unsigned VEC_REGS = 4;
   localparam int unsigned NUM_REGS = 2 ** SEL_BITS;

   typedef logic [SEL_BITS-1:0] reg_addr_t;
   typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0] vec_data_t;

   typedef struct packed {
      reg_addr_t addr;
      vec_data_t data;
   } wb_write_t;

   function automatic logic is_vector_reg(reg_addr_t r);
      return 32'(r) < VEC_REGS;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: per-requester valid/ready with destination and data.
interface regfile_wb_arbiter_if
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3
);

   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   reg_addr_t [NUM_REQ-1:0] req_reg;
   vec_data_t [NUM_REQ-1:0] req_data;

   modport master (output req_valid, output req_reg, output req_data, input req_ready);
   modport slave  (input req_valid, input req_reg, input req_data, output req_ready);

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Reusable N-way arbiter with one-hot grant; round-robin by default,
// fixed lowest-index priority when WB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
   parameter int unsigned N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

`ifdef WB_FIXED_PRIO_EN
   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !found) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
      if (reset) grant = '0;
   end
`else
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic          found;

   // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
   always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !found && i >= 32'(ptr_q)) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            ptr_d    = PW'((i + 1) % N);
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !found) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            ptr_d    = PW'((i + 1) % N);
         end
      end
      if (reset) begin
         grant = '0;
         ptr_d = ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto the reg_file write port and
// tracks pending writes per register. Optional macro: WB_FIXED_PRIO_EN.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   regfile_wb_arbiter_if.slave   wb,
   input  logic                  claim_valid,
   input  reg_addr_t             claim_reg,
   output logic                  claim_conflict,
   input  reg_addr_t             rd_sel1,
   input  reg_addr_t             rd_sel2,
   output logic                  rd_busy1,
   output logic                  rd_busy2,
   output logic                  regWrEnSc,
   output logic                  regWrEnVec,
   output reg_addr_t             regToWrite,
   output vec_data_t             dataIn
);

   logic [NUM_REQ-1:0]  grant;
   logic                accept;
   wb_write_t           sel;
   wb_write_t           wr_q, wr_d;
   logic                wr_sc_q, wr_sc_d;
   logic                wr_vec_q, wr_vec_d;
   logic                strobe;
   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [NUM_REGS-1:0] set_vec, clr_vec;
   logic                conflict_q, conflict_d;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (wb.req_valid),
      .grant (grant)
   );

   assign wb.req_ready = grant;

   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel.addr = wb.req_reg[i];
            sel.data = wb.req_data[i];
         end
      end
      accept   = |grant;
      wr_sc_d  = accept && !is_vector_reg(sel.addr);
      wr_vec_d = accept && is_vector_reg(sel.addr);
      wr_d     = accept ? sel : wr_q;
   end

   // Reset in the cycle a strobe is visible drops that write before reg_file commits it.
   assign strobe     = (wr_sc_q | wr_vec_q) & ~reset;
   assign regWrEnSc  = wr_sc_q & ~reset;
   assign regWrEnVec = wr_vec_q & ~reset;
   assign regToWrite = wr_q.addr;
   assign dataIn     = wr_q.data;

   // A claim landing on the register being cleared re-arms it: the newer producer wins.
   always_comb begin
      set_vec    = claim_valid ? (NUM_REGS'(1) << claim_reg) : '0;
      clr_vec    = strobe ? (NUM_REGS'(1) << wr_q.addr) : '0;
      pending_d  = (pending_q & ~clr_vec) | set_vec;
      conflict_d = claim_valid & pending_q[claim_reg] & ~clr_vec[claim_reg];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q       <= '0;
         wr_sc_q    <= 1'b0;
         wr_vec_q   <= 1'b0;
         pending_q  <= '0;
         conflict_q <= 1'b0;
      end else begin
         wr_q       <= wr_d;
         wr_sc_q    <= wr_sc_d;
         wr_vec_q   <= wr_vec_d;
         pending_q  <= pending_d;
         conflict_q <= conflict_d;
      end
   end

   assign claim_conflict = conflict_q;
   assign rd_busy1       = pending_q[rd_sel1];
   assign rd_busy2       = pending_q[rd_sel2];

endmodule
